// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: handshake state encoding
// and the pointer width helper derived from FIFO depth.
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACK   = 2'd1,
      STALL = 2'd2
   } rx_state_e;

   // Width of a pointer addressing DEPTH entries; count needs one extra bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; writes are ignored when full and
// reads are ignored when empty, both judged on the registered count.
module uart_rx_fifo
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        wr_en,
   input  logic [WIDTH-1:0]            wr_data,
   input  logic                        rd_en,
   output logic [WIDTH-1:0]            rd_data,
   output logic                        full,
   output logic                        empty,
   output logic [ptr_width(DEPTH):0]   count
);

   localparam int PW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [PW:0]      count_reg;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count_reg == (PW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_reg] <= wr_data;
      end
   end

   // DEPTH is a power of two, so pointer increments wrap naturally.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: services the receiver REQ/ACK handshake, buffers
// bytes in a FWFT FIFO and tracks bytes dropped while the FIFO is full.
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter bit STALL_ON_FULL = 1'b0
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic                        rcv_req,
   input  logic [7:0]                  rcv_data,
   output logic                        rcv_ack,
   output logic                        out_valid,
   output logic [7:0]                  out_data,
   input  logic                        out_ready,
   output logic [ptr_width(DEPTH):0]   fifo_count,
   output logic                        overrun,
   output logic [7:0]                  drop_cnt,
   input  logic                        ovr_clear
);

   rx_state_e  state_reg;
   rx_state_e  state_next;
   logic       wr_en;
   logic       drop;
   logic       full;
   logic       empty;
   logic       overrun_reg;
   logic [7:0] drop_cnt_reg;

   uart_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .clr     (clr),
      .wr_en   (wr_en),
      .wr_data (rcv_data),
      .rd_en   (out_ready),
      .rd_data (out_data),
      .full    (full),
      .empty   (empty),
      .count   (fifo_count)
   );

   assign out_valid = ~empty;
   assign rcv_ack   = (state_reg == ACK);
   assign overrun   = overrun_reg;
   assign drop_cnt  = drop_cnt_reg;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) state_reg <= IDLE;
      else      state_reg <= state_next;
   end

   // Captures happen only on the IDLE/STALL exit, so a req held across ACK
   // can never write twice.
   always_comb begin
      state_next = state_reg;
      wr_en      = 1'b0;
      drop       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rcv_req) begin
               if (!full) begin
                  wr_en      = 1'b1;
                  state_next = ACK;
               end else if (STALL_ON_FULL) begin
                  state_next = STALL;
               end else begin
                  drop       = 1'b1;
                  state_next = ACK;
               end
            end
         end
         STALL: begin
            if (!full) begin
               wr_en      = 1'b1;
               state_next = ACK;
            end
         end
         ACK: begin
            if (!rcv_req) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // A drop in the same cycle as ovr_clear restarts the count at one.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         overrun_reg  <= 1'b0;
         drop_cnt_reg <= '0;
      end else if (drop) begin
         overrun_reg <= 1'b1;
         if (ovr_clear)                  drop_cnt_reg <= 8'd1;
         else if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end else if (ovr_clear) begin
         overrun_reg  <= 1'b0;
         drop_cnt_reg <= '0;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: instance 0 drops on full, instance 1 stalls;
// accepted bytes are tracked in per-instance scoreboards.
module tb_uart_rx_ctrl;

   logic       clk;
   logic       clr;
   logic       req       [2];
   logic [7:0] data      [2];
   logic       rdy       [2];
   logic       oclr      [2];
   logic       ack       [2];
   logic       valid     [2];
   logic [7:0] odata     [2];
   logic [2:0] cnt       [2];
   logic       ovr       [2];
   logic [7:0] dcnt      [2];

   logic [7:0] sb0[$];
   logic [7:0] sb1[$];
   int         tests;
   int         fails;
   int         exp_drops;

   uart_rx_ctrl #(.DEPTH(4), .STALL_ON_FULL(1'b0)) dut0 (
      .clk(clk), .clr(clr), .rcv_req(req[0]), .rcv_data(data[0]), .rcv_ack(ack[0]),
      .out_valid(valid[0]), .out_data(odata[0]), .out_ready(rdy[0]),
      .fifo_count(cnt[0]), .overrun(ovr[0]), .drop_cnt(dcnt[0]), .ovr_clear(oclr[0])
   );

   uart_rx_ctrl #(.DEPTH(4), .STALL_ON_FULL(1'b1)) dut1 (
      .clk(clk), .clr(clr), .rcv_req(req[1]), .rcv_data(data[1]), .rcv_ack(ack[1]),
      .out_valid(valid[1]), .out_data(odata[1]), .out_ready(rdy[1]),
      .fifo_count(cnt[1]), .overrun(ovr[1]), .drop_cnt(dcnt[1]), .ovr_clear(oclr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int sb_size(input int i);
      return (i == 0) ? sb0.size() : sb1.size();
   endfunction

   function automatic logic [7:0] sb_front(input int i);
      return (i == 0) ? sb0[0] : sb1[0];
   endfunction

   // One full handshake; the model decides accept vs drop from its own occupancy.
   task automatic send(input int i, input logic [7:0] b);
      bit accept;
      accept  = (sb_size(i) < 4);
      req[i]  = 1'b1;
      data[i] = b;
      tick();
      check("ack_rise", 32'(ack[i]), 32'd1);
      if (accept) begin
         if (i == 0) sb0.push_back(b);
         else        sb1.push_back(b);
      end else begin
         exp_drops = (exp_drops < 255) ? exp_drops + 1 : 255;
      end
      req[i] = 1'b0;
      tick();
      check("ack_fall", 32'(ack[i]), 32'd0);
   endtask

   task automatic drain(input int i);
      rdy[i] = 1'b1;
      while (sb_size(i) > 0) begin
         check("drain_valid", 32'(valid[i]), 32'd1);
         check("drain_data", 32'(odata[i]), 32'(sb_front(i)));
         if (i == 0) void'(sb0.pop_front());
         else        void'(sb1.pop_front());
         tick();
      end
      rdy[i] = 1'b0;
      check("drain_count", 32'(cnt[i]), 32'd0);
      check("drain_empty", 32'(valid[i]), 32'd0);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      exp_drops = 0;
      clr       = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i]  = 1'b0;
         data[i] = 8'h00;
         rdy[i]  = 1'b0;
         oclr[i] = 1'b0;
      end
      #12;
      check("rst_ack", 32'(ack[0]), 32'd0);
      check("rst_valid", 32'(valid[0]), 32'd0);
      check("rst_count", 32'(cnt[0]), 32'd0);
      check("rst_ovr", 32'(ovr[0]), 32'd0);
      check("rst_drops", 32'(dcnt[0]), 32'd0);
      @(negedge clk);
      clr = 1'b1;
      tick();

      // Single byte with first-word-fall-through head.
      req[0]  = 1'b1;
      data[0] = 8'h5A;
      tick();
      sb0.push_back(8'h5A);
      check("single_ack", 32'(ack[0]), 32'd1);
      check("single_valid", 32'(valid[0]), 32'd1);
      check("single_data", 32'(odata[0]), 32'h5A);
      check("single_count", 32'(cnt[0]), 32'd1);
      tick();
      check("single_held_count", 32'(cnt[0]), 32'd1);
      req[0] = 1'b0;
      tick();
      check("single_ack_fall", 32'(ack[0]), 32'd0);
      drain(0);

      // Fill then drain on consecutive cycles.
      for (int b = 1; b <= 4; b++) send(0, 8'(b));
      check("fill_count", 32'(cnt[0]), 32'd4);
      drain(0);

      // Overrun with drop-on-full.
      for (int b = 0; b < 4; b++) send(0, 8'h10 + 8'(b));
      send(0, 8'hEE);
      send(0, 8'hEF);
      check("ovr_flag", 32'(ovr[0]), 32'd1);
      check("ovr_drops", 32'(dcnt[0]), 32'(exp_drops));
      check("ovr_count", 32'(cnt[0]), 32'd4);
      check("ovr_head", 32'(odata[0]), 32'h10);
      oclr[0] = 1'b1;
      tick();
      oclr[0]   = 1'b0;
      exp_drops = 0;
      check("clr_flag", 32'(ovr[0]), 32'd0);
      check("clr_drops", 32'(dcnt[0]), 32'd0);

      // Drop coinciding with ovr_clear restarts the count at one.
      send(0, 8'hE0);
      check("pre_coinc_drops", 32'(dcnt[0]), 32'd1);
      oclr[0] = 1'b1;
      req[0]  = 1'b1;
      data[0] = 8'hE1;
      tick();
      oclr[0] = 1'b0;
      req[0]  = 1'b0;
      exp_drops = 1;
      check("coinc_flag", 32'(ovr[0]), 32'd1);
      check("coinc_drops", 32'(dcnt[0]), 32'(exp_drops));
      tick();

      // Saturation after 300 further drops.
      for (int k = 0; k < 300; k++) send(0, 8'(k));
      check("sat_drops", 32'(dcnt[0]), 32'd255);
      check("sat_flag", 32'(ovr[0]), 32'd1);
      check("sat_count", 32'(cnt[0]), 32'd4);
      drain(0);

      // Simultaneous write and read at count 2.
      send(0, 8'h20);
      send(0, 8'h21);
      check("sim_pre_count", 32'(cnt[0]), 32'd2);
      check("sim_head", 32'(odata[0]), 32'(sb0[0]));
      rdy[0]  = 1'b1;
      req[0]  = 1'b1;
      data[0] = 8'h22;
      void'(sb0.pop_front());
      sb0.push_back(8'h22);
      tick();
      rdy[0] = 1'b0;
      check("sim_count", 32'(cnt[0]), 32'd2);
      check("sim_ack", 32'(ack[0]), 32'd1);
      check("sim_new_head", 32'(odata[0]), 32'h21);
      req[0] = 1'b0;
      tick();
      drain(0);

      // Stall-on-full instance: ACK withheld until a slot frees.
      for (int b = 0; b < 4; b++) send(1, 8'hA0 + 8'(b));
      req[1]  = 1'b1;
      data[1] = 8'h77;
      tick();
      check("stall_ack0", 32'(ack[1]), 32'd0);
      tick();
      check("stall_ack1", 32'(ack[1]), 32'd0);
      check("stall_count", 32'(cnt[1]), 32'd4);
      check("stall_head", 32'(odata[1]), 32'(sb1[0]));
      rdy[1] = 1'b1;
      void'(sb1.pop_front());
      tick();
      rdy[1] = 1'b0;
      check("stall_after_read_count", 32'(cnt[1]), 32'd3);
      check("stall_after_read_ack", 32'(ack[1]), 32'd0);
      tick();
      sb1.push_back(8'h77);
      check("stall_exit_ack", 32'(ack[1]), 32'd1);
      check("stall_exit_count", 32'(cnt[1]), 32'd4);
      check("stall_no_drop", 32'(dcnt[1]), 32'd0);
      req[1] = 1'b0;
      tick();
      check("stall_ack_fall", 32'(ack[1]), 32'd0);
      drain(1);

      // Asynchronous reset during ACK, then a still-high req is a new request.
      req[0]  = 1'b1;
      data[0] = 8'h33;
      tick();
      check("prerst_ack", 32'(ack[0]), 32'd1);
      check("prerst_count", 32'(cnt[0]), 32'd1);
      clr = 1'b0;
      #1;
      check("midrst_ack", 32'(ack[0]), 32'd0);
      check("midrst_count", 32'(cnt[0]), 32'd0);
      check("midrst_ovr", 32'(ovr[0]), 32'd0);
      @(negedge clk);
      clr     = 1'b1;
      data[0] = 8'h44;
      tick();
      sb0.delete();
      sb0.push_back(8'h44);
      check("postrst_ack", 32'(ack[0]), 32'd1);
      check("postrst_count", 32'(cnt[0]), 32'd1);
      req[0] = 1'b0;
      tick();
      check("postrst_ack_fall", 32'(ack[0]), 32'd0);
      drain(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller for the UART receiver. It services the receiver's four-phase REQ/ACK byte handshake and buffers accepted bytes in a small FIFO. It presents them to the downstream consumer over a valid/ready interface. It also tracks overruns, so the receiver never blocks on a slow consumer unless configured to.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥ 2.
- STALL_ON_FULL, 0: 0 = acknowledge and drop the byte when full; 1 = withhold ACK until space frees.
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  reset, asynchronous, active-low.
- rcv_req  in  1  receiver byte-ready request; synchronous to clk.
- rcv_data  in  8  receiver byte; stable while rcv_req=1.
- rcv_ack  out  1  acknowledge to receiver.
- out_valid  out  1  FIFO head valid.
- out_data  out  8  FIFO head byte (first-word-fall-through).
- out_ready  in  1  consumer accepts head when out_valid=1.
- fifo_count  out  $clog2(DEPTH)+1  occupied entries.
- overrun  out  1  sticky: at least one byte dropped.
- drop_cnt  out  8  dropped-byte count, saturates at 255.
- ovr_clear  in  1  clears overrun and drop_cnt.

## Operation
- Handshake FSM states: IDLE, ACK, STALL.
  - IDLE, rcv_req=1, FIFO not full: write rcv_data, go to ACK.
  - IDLE, rcv_req=1, full, STALL_ON_FULL=0: discard the byte, set overrun, increment drop_cnt, go to ACK.
  - IDLE, rcv_req=1, full, STALL_ON_FULL=1: go to STALL; no write.
  - STALL: when the FIFO is not full, write rcv_data and go to ACK.
  - ACK: rcv_ack=1; when rcv_req is sampled 0, go to IDLE.
- rcv_ack is registered and equals (state==ACK).
- Exactly one capture per handshake. rcv_req held high across ACK never causes a second write.
- FIFO:
  - Write pointer, read pointer and count are registered; pointers wrap modulo DEPTH.
  - out_valid = (count != 0); out_data = mem[rd_ptr].
  - A read occurs when out_valid & out_ready.
- "Full" means count == DEPTH, using the registered count. A write is rejected when full even if a read happens in the same cycle; the freed slot is usable next cycle.
- A simultaneous write and read while not full leaves the count unchanged; both pointers advance.
- out_ready with out_valid=0 is ignored; there is no underflow.
- If ovr_clear coincides with a drop, the drop wins: overrun=1, drop_cnt=1.

## Timing
- Reset (clr=0) sets state=IDLE, rcv_ack=0, count=0, pointers=0, out_valid=0, overrun=0, drop_cnt=0. out_data is don't-care while empty.
- Reset mid-handshake drops ACK immediately (asynchronous). After release, a still-high rcv_req is treated as a new request.
- Write latency:
  - rcv_req seen high at edge N: rcv_ack=1 and out_valid=1 (if previously empty) after edge N.
  - rcv_req seen low at edge M: rcv_ack=0 after edge M.
- Minimum handshake: 2 cycles per byte, given a combinational req drop by the receiver.
- STALL exit: the first edge with count<DEPTH performs the write; ACK follows that edge.
- A read takes effect at the edge; the new head appears on out_data after that edge.

## Structure
- Shared package: FSM state encoding (IDLE=2'd0, ACK=2'd1, STALL=2'd2) and the DEPTH-derived pointer-width function.
- One sub-module, uart_rx_fifo: a synchronous FWFT FIFO with wr_en/rd_en, full/empty and count.
- The FSM and overrun logic stay in uart_rx_ctrl.

## Test plan
- Single byte: rcv_req=1 with 0x5A; out_ready=0 → rcv_ack rises next cycle, out_valid=1, out_data=0x5A, fifo_count=1. Drop rcv_req → rcv_ack=0 next cycle.
- Fill and drain: send 0x01..0x04 with out_ready=0 → fifo_count=4. Then out_ready=1 → bytes 0x01..0x04 appear on consecutive cycles, and fifo_count returns to 0.
- Overrun, STALL_ON_FULL=0: fill with 4 bytes, send 0xEE and 0xEF → both ACKed, overrun=1, drop_cnt=2, FIFO contents unchanged. Pulse ovr_clear → overrun=0, drop_cnt=0.
- Stall, STALL_ON_FULL=1: full FIFO, send 0x77 → rcv_ack stays 0. One cycle of out_ready → 0x77 written on the following edge, rcv_ack=1, fifo_count=4.
- Simultaneous: count=2, a write and a read in the same cycle → count stays 2 and order is preserved. Reset asserted during ACK → rcv_ack=0, fifo_count=0 immediately.
- Saturation: 300 drops → drop_cnt=255, overrun=1.
